// File: rtl/fp_pkg.sv
// Shared FP32 compare/classify definitions: op encodings, field widths, class-mask bit
// positions and the per-operand classification record.
package fp_pkg;

   localparam int FP_FLEN  = 32;
   localparam int FP_XLEN  = 32;
   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

   localparam logic [FP_EXP_W-1:0] FP_EXP_ONES   = 8'hFF;
   localparam logic [FP_FLEN-1:0]  FP_CANON_QNAN = 32'h7FC0_0000;

   // funct3 order of the RV32F compare group, FCLASS borrowed into the spare code
   typedef enum logic [1:0] {
      FP_OP_FLE    = 2'b00,
      FP_OP_FLT    = 2'b01,
      FP_OP_FEQ    = 2'b10,
      FP_OP_FCLASS = 2'b11
   } fp_op_e;

   localparam int FC_W        = 10;
   localparam int FC_NEG_INF  = 0;
   localparam int FC_NEG_NORM = 1;
   localparam int FC_NEG_SUB  = 2;
   localparam int FC_NEG_ZERO = 3;
   localparam int FC_POS_ZERO = 4;
   localparam int FC_POS_SUB  = 5;
   localparam int FC_POS_NORM = 6;
   localparam int FC_POS_INF  = 7;
   localparam int FC_SNAN     = 8;
   localparam int FC_QNAN     = 9;

   typedef struct packed {
      logic            is_nan;
      logic            is_snan;
      logic            is_zero;
      logic [FC_W-1:0] mask;
   } fp_class_t;

endpackage

// File: rtl/fp_cmp_unit_if.sv
// Valid/ready operand and result channels of the FP compare/classify unit.
interface fp_cmp_unit_if;
   import fp_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [1:0]         op;
   logic [FP_FLEN-1:0] a;
   logic [FP_FLEN-1:0] b;
   logic               out_valid;
   logic               out_ready;
   logic [FP_XLEN-1:0] result;
   logic               nv_flag;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, nv_flag
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, nv_flag
   );

endinterface

// File: rtl/fp_classify.sv
// Combinational FP32 operand classifier. The one-hot FCLASS mask exists only when
// FP_CMP_FCLASS_EN is defined; NaN/sNaN/zero detection is always present.
module fp_classify
   import fp_pkg::*;
(
   input  logic [FP_FLEN-1:0] x_i,
   output fp_class_t          cls_o
);

   logic [FP_EXP_W-1:0] exp_f;
   logic [FP_MAN_W-1:0] man_f;
   logic                exp_ones;
   logic                exp_zero;
   logic                man_zero;

   assign exp_f    = x_i[FP_FLEN-2 -: FP_EXP_W];
   assign man_f    = x_i[FP_MAN_W-1:0];
   assign exp_ones = (exp_f == FP_EXP_ONES);
   assign exp_zero = (exp_f == '0);
   assign man_zero = (man_f == '0);

`ifdef FP_CMP_FCLASS_EN
   logic sign_f;
   assign sign_f = x_i[FP_FLEN-1];
`else
   logic unused_sign;
   assign unused_sign = x_i[FP_FLEN-1];
`endif

   always_comb begin
      cls_o         = '0;
      cls_o.is_nan  = exp_ones && !man_zero;
      // quiet bit is the mantissa MSB; clear means signalling
      cls_o.is_snan = exp_ones && !man_zero && !man_f[FP_MAN_W-1];
      cls_o.is_zero = exp_zero && man_zero;
`ifdef FP_CMP_FCLASS_EN
      if (exp_ones && !man_zero) begin
         if (man_f[FP_MAN_W-1]) cls_o.mask[FC_QNAN] = 1'b1;
         else                   cls_o.mask[FC_SNAN] = 1'b1;
      end else if (exp_ones) begin
         if (sign_f) cls_o.mask[FC_NEG_INF] = 1'b1;
         else        cls_o.mask[FC_POS_INF] = 1'b1;
      end else if (exp_zero && man_zero) begin
         if (sign_f) cls_o.mask[FC_NEG_ZERO] = 1'b1;
         else        cls_o.mask[FC_POS_ZERO] = 1'b1;
      end else if (exp_zero) begin
         if (sign_f) cls_o.mask[FC_NEG_SUB] = 1'b1;
         else        cls_o.mask[FC_POS_SUB] = 1'b1;
      end else begin
         if (sign_f) cls_o.mask[FC_NEG_NORM] = 1'b1;
         else        cls_o.mask[FC_POS_NORM] = 1'b1;
      end
`endif
   end

endmodule

// File: rtl/fp_cmp_unit.sv
// Two-stage elastic RV32F FEQ/FLT/FLE (+ FCLASS when FP_CMP_FCLASS_EN is defined) unit.
// S1 holds operands and their classes, S2 holds the integer result and NV flag.
module fp_cmp_unit
   import fp_pkg::*;
#(
   parameter int FLEN = 32,
   parameter int XLEN = 32
)(
   input  logic          clk,
   input  logic          rst_n,
   fp_cmp_unit_if.slave  cmp_if
);

   fp_class_t cls_a;
   fp_class_t cls_b;

   fp_classify u_cls_a (.x_i(cmp_if.a), .cls_o(cls_a));
   fp_classify u_cls_b (.x_i(cmp_if.b), .cls_o(cls_b));

   logic            s1_valid_q, s1_valid_d;
   fp_op_e          s1_op_q;
   logic [FLEN-1:0] s1_a_q, s1_b_q;
   fp_class_t       s1_cls_a_q, s1_cls_b_q;

   logic            s2_valid_q;
   logic [XLEN-1:0] s2_result_q, s2_result_d;
   logic            s2_nv_q, s2_nv_d;

   logic s2_adv;
   logic in_ready;
   logic accept;

   // S1 always drains into S2 when S2 moves, so S1 may refill on that same cycle
   assign s2_adv     = !s2_valid_q || cmp_if.out_ready;
   assign in_ready   = !s1_valid_q || s2_adv;
   assign accept     = cmp_if.in_valid && in_ready;
   assign s1_valid_d = in_ready ? accept : s1_valid_q;

   assign cmp_if.in_ready  = in_ready;
   assign cmp_if.out_valid = s2_valid_q;
   assign cmp_if.result    = s2_result_q;
   assign cmp_if.nv_flag   = s2_nv_q;

   logic            sign_a, sign_b;
   logic [FLEN-2:0] mag_a, mag_b;
   logic            any_nan, any_snan, both_zero;
   logic            eq_raw, lt_raw;

   assign sign_a    = s1_a_q[FLEN-1];
   assign sign_b    = s1_b_q[FLEN-1];
   assign mag_a     = s1_a_q[FLEN-2:0];
   assign mag_b     = s1_b_q[FLEN-2:0];
   assign any_nan   = s1_cls_a_q.is_nan  || s1_cls_b_q.is_nan;
   assign any_snan  = s1_cls_a_q.is_snan || s1_cls_b_q.is_snan;
   assign both_zero = s1_cls_a_q.is_zero && s1_cls_b_q.is_zero;
   assign eq_raw    = (s1_a_q == s1_b_q) || both_zero;

   always_comb begin
      lt_raw = 1'b0;
      if (both_zero)             lt_raw = 1'b0;
      else if (sign_a != sign_b) lt_raw = sign_a;
      else if (sign_a)           lt_raw = (mag_a > mag_b);
      else                       lt_raw = (mag_a < mag_b);
   end

   always_comb begin
      s2_result_d = '0;
      s2_nv_d     = 1'b0;
      case (s1_op_q)
         FP_OP_FEQ: begin
            s2_result_d[0] = !any_nan && eq_raw;
            s2_nv_d        = any_snan;
         end
         FP_OP_FLT: begin
            s2_result_d[0] = !any_nan && lt_raw;
            s2_nv_d        = any_nan;
         end
         FP_OP_FLE: begin
            s2_result_d[0] = !any_nan && (lt_raw || eq_raw);
            s2_nv_d        = any_nan;
         end
         default: begin
`ifdef FP_CMP_FCLASS_EN
            s2_result_d[FC_W-1:0] = s1_cls_a_q.mask;
`endif
         end
      endcase
   end

`ifdef FP_CMP_FCLASS_EN
   logic unused_mask;
   assign unused_mask = ^s1_cls_b_q.mask;
`else
   logic unused_mask;
   assign unused_mask = ^{s1_cls_a_q.mask, s1_cls_b_q.mask};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_nv_q     <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_result_q <= s2_result_d;
               s2_nv_q     <= s2_nv_d;
            end
         end
      end
   end

   // operand payload needs no reset: it is only observed behind s1_valid_q
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_op_q    <= fp_op_e'(cmp_if.op);
         s1_a_q     <= cmp_if.a;
         s1_b_q     <= cmp_if.b;
         s1_cls_a_q <= cls_a;
         s1_cls_b_q <= cls_b;
      end
   end

endmodule

// File: tb/tb_fp_cmp_unit.sv
// Scoreboard bench for fp_cmp_unit: directed corner cases, back-to-back stalls, random
// traffic against a real-valued reference model, and a mid-stream reset.
module tb_fp_cmp_unit;
   import fp_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fp_cmp_unit_if cmp_if ();

   fp_cmp_unit #(.FLEN(32), .XLEN(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .cmp_if (cmp_if)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        nv;
   } txn_t;

   txn_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;
   int   rdy_cnt = 0;

   // ---------------- reference model ----------------
   function automatic real pow2(input int k);
      real r = 1.0;
      if (k >= 0) repeat (k) r = r * 2.0;
      else        repeat (-k) r = r / 2.0;
      return r;
   endfunction

   function automatic bit is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 0);
   endfunction

   // numeric value; infinities map beyond any finite FP32 magnitude
   function automatic real fp_value(input logic [31:0] x);
      int  e = int'(x[30:23]);
      real m = real'(x[22:0]);
      real v;
      if (e == 255)    v = 1.0e40;
      else if (e == 0) v = m * pow2(-149);
      else             v = (1.0 + m / 8388608.0) * pow2(e - 127);
      return x[31] ? -v : v;
   endfunction

   function automatic int class_idx(input logic [31:0] x);
      if (is_nan(x))              return x[22] ? FC_QNAN : FC_SNAN;
      if (x[30:23] == 8'hFF)      return x[31] ? FC_NEG_INF : FC_POS_INF;
      if (fp_value(x) == 0.0)     return x[31] ? FC_NEG_ZERO : FC_POS_ZERO;
      if (x[30:23] == 8'h00)      return x[31] ? FC_NEG_SUB : FC_POS_SUB;
      return x[31] ? FC_NEG_NORM : FC_POS_NORM;
   endfunction

   function automatic txn_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      txn_t t;
      real  va, vb;
      t.op = op; t.a = a; t.b = b; t.res = 0; t.nv = 1'b0;
      if (op == FP_OP_FCLASS) begin
`ifdef FP_CMP_FCLASS_EN
         t.res[class_idx(a)] = 1'b1;
`endif
      end else if (is_nan(a) || is_nan(b)) begin
         if (op == FP_OP_FEQ) t.nv = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
         else                 t.nv = 1'b1;
      end else begin
         va = fp_value(a);
         vb = fp_value(b);
         case (op)
            FP_OP_FLE: t.res[0] = (va <= vb);
            FP_OP_FLT: t.res[0] = (va < vb);
            default:   t.res[0] = (va == vb);
         endcase
      end
      return t;
   endfunction

   // ---------------- driver ----------------
   // Called at a negedge; returns at the negedge following acceptance.
   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic nv);
      txn_t t;
      bit   acc = 0;
      cmp_if.in_valid = 1'b1;
      cmp_if.op = op; cmp_if.a = a; cmp_if.b = b;
      for (int w = 0; w < 200 && !acc; w++) begin
         #1;
         if (cmp_if.in_ready) begin
            t.op = op; t.a = a; t.b = b; t.res = res; t.nv = nv;
            sb.push_back(t);
            acc = 1;
         end
         @(negedge clk);
      end
      if (!acc) begin
         checks++; errors++;
         $display("FAIL in_ready_timeout op=%0d a=%h: in_ready=0 required 1", op, a);
      end
      cmp_if.in_valid = 1'b0;
   endtask

   task automatic send_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      txn_t t;
      t = model(op, a, b);
      send(op, a, b, t.res, t.nv);
   endtask

   task automatic idle(input int n);
      cmp_if.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   logic [31:0] specials [12] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                   FP_CANON_QNAN, 32'h7F80_0001, 32'hFFC0_0001, 32'h0000_0001,
                                   32'h807F_FFFF, 32'h3F80_0000, 32'hBF80_0000, 32'h7F7F_FFFF};

   function automatic logic [31:0] rand_fp();
      case ($urandom % 4)
         0:       return specials[$urandom % 12];
         1:       return {1'($urandom), 8'(8'd120 + 8'($urandom % 16)), 23'($urandom)};
         default: return $urandom;
      endcase
   endfunction

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      bit          held = 0;
      logic [31:0] hres;
      logic        hnv;
      txn_t        e;
      cmp_if.out_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       cmp_if.out_ready = 1'b1;
            1:       cmp_if.out_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
            default: cmp_if.out_ready = ($urandom % 3) != 0;
         endcase
         rdy_cnt++;
         #1;
         if (!rst_n) begin
            held = 0;
            continue;
         end
         if (cmp_if.out_valid) begin
            if (held) begin
               checks++;
               if (cmp_if.result !== hres || cmp_if.nv_flag !== hnv) begin
                  errors++;
                  $display("FAIL stall_stable: result=%h nv=%b required result=%h nv=%b",
                           cmp_if.result, cmp_if.nv_flag, hres, hnv);
               end
            end
            if (cmp_if.out_ready) begin
               held = 0;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat: out_valid=1 result=%h required no beat", cmp_if.result);
               end else begin
                  e = sb.pop_front();
                  $display("txn op=%0d a=%h b=%h result=%h nv=%b", e.op, e.a, e.b,
                           cmp_if.result, cmp_if.nv_flag);
                  if (cmp_if.result !== e.res || cmp_if.nv_flag !== e.nv) begin
                     errors++;
                     $display("FAIL result op=%0d a=%h b=%h: result=%h nv=%b required result=%h nv=%b",
                              e.op, e.a, e.b, cmp_if.result, cmp_if.nv_flag, e.res, e.nv);
                  end
               end
            end else begin
               held = 1; hres = cmp_if.result; hnv = cmp_if.nv_flag;
            end
         end else if (held) begin
            held = 0;
            checks++; errors++;
            $display("FAIL dropped_beat: out_valid=0 required 1 while stalled");
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic check_idle_outputs(input string name);
      checks++;
      if (cmp_if.out_valid !== 1'b0 || cmp_if.result !== 32'h0 || cmp_if.nv_flag !== 1'b0
          || cmp_if.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s: out_valid=%b result=%h nv=%b in_ready=%b required 0 0 0 1", name,
                  cmp_if.out_valid, cmp_if.result, cmp_if.nv_flag, cmp_if.in_ready);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      rdy_mode = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL %s_drain: %0d beats outstanding required 0", name, sb.size());
         sb.delete();
      end
      idle(3);
   endtask

   initial begin : stim
      logic [31:0] a, b;
      logic [1:0]  op;
      cmp_if.in_valid = 1'b0;
      cmp_if.op = 2'b00; cmp_if.a = '0; cmp_if.b = '0;
      #1 rst_n = 1'b0;
      #2 check_idle_outputs("reset_state");
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);

      // directed corner cases with hand-derived expectations
      send(FP_OP_FLT, 32'h3F80_0000, 32'h4000_0000, 32'd1, 1'b0);
      send(FP_OP_FLT, 32'h4000_0000, 32'h3F80_0000, 32'd0, 1'b0);
      send(FP_OP_FEQ, 32'h0000_0000, 32'h8000_0000, 32'd1, 1'b0);
      send(FP_OP_FLE, 32'h0000_0000, 32'h8000_0000, 32'd1, 1'b0);
      send(FP_OP_FLT, 32'h0000_0000, 32'h8000_0000, 32'd0, 1'b0);
      send(FP_OP_FEQ, 32'h7FC0_0000, 32'h3F80_0000, 32'd0, 1'b0);
      send(FP_OP_FEQ, 32'h7F80_0001, 32'h3F80_0000, 32'd0, 1'b1);
      send(FP_OP_FLT, 32'h7FC0_0000, 32'h3F80_0000, 32'd0, 1'b1);
      send(FP_OP_FLE, 32'hFF80_0000, 32'hC000_0000, 32'd1, 1'b0);
      send(FP_OP_FLT, 32'hC000_0000, 32'hBF80_0000, 32'd1, 1'b0);
`ifdef FP_CMP_FCLASS_EN
      send(FP_OP_FCLASS, 32'h0000_0001, 32'h1234_5678, 32'h020, 1'b0);
      send(FP_OP_FCLASS, 32'hFF80_0000, 32'h0, 32'h001, 1'b0);
      send(FP_OP_FCLASS, 32'h7F80_0001, 32'hFFFF_FFFF, 32'h100, 1'b0);
`else
      send(FP_OP_FCLASS, 32'h0000_0001, 32'h1234_5678, 32'h0, 1'b0);
      send(FP_OP_FCLASS, 32'hFF80_0000, 32'h0, 32'h0, 1'b0);
      send(FP_OP_FCLASS, 32'h7F80_0001, 32'hFFFF_FFFF, 32'h0, 1'b0);
`endif
      drain("directed");

      // back-to-back with out_ready pattern 1,0,0,1
      rdy_mode = 1; rdy_cnt = 0;
      for (int i = 0; i < 8; i++)
         send_model(2'(i % 4), rand_fp(), rand_fp());
      drain("b2b");

      // random traffic with random backpressure and input gaps
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         a  = rand_fp();
         op = 2'($urandom % 4);
         case ($urandom % 4)
            0:       b = a;
            1:       b = a ^ 32'h8000_0000;
            default: b = rand_fp();
         endcase
         send_model(op, a, b);
         if ($urandom % 5 == 0) idle(1 + $urandom % 2);
      end
      drain("random");

      // reset with beats in flight: everything is dropped
      rdy_mode = 1; rdy_cnt = 1;
      for (int i = 0; i < 4; i++)
         send_model(FP_OP_FLE, rand_fp(), rand_fp());
      cmp_if.in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1 check_idle_outputs("reset_midstream");
      sb.delete();
      @(negedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 check_idle_outputs("post_reset_idle");
      end
      @(negedge clk);
      rdy_mode = 0;
      send(FP_OP_FEQ, 32'h3F80_0000, 32'h3F80_0000, 32'd1, 1'b0);
      send_model(FP_OP_FLT, 32'hBF80_0000, 32'h0000_0000);
      drain("recovery");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
